mult_div_seq: RTL and testbench

- Multi-cycle sequencer for MULT/DIV, the producer of the HI/LO register inputs.
- The main control FSM pulses a start, then waits on busy/done before enabling WriteHI/WriteLO.
- One shared iterative datapath is used: radix-2 Booth for multiply, restoring division for divide.
- One iteration per clock, so the ALU is never borrowed.

---
 rtl/mult_div_pkg.sv | 21 ++
 rtl/mult_div_seq_if.sv | 38 +++
 rtl/mult_div_seq_md_step.sv | 45 ++++
 rtl/mult_div_seq.sv | 187 ++++++++++++++++++
 tb/tb_mult_div_seq.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mult_div_pkg.sv
// Shared types and constants for the MULT/DIV sequencer: FSM state encoding,
// default operand width and the iteration-counter width.
package mult_div_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = $clog2(MD_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        MUL_IT,
        DIV_IT,
        FIXUP,
        DONE
    } md_state_e;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int md_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_div_seq_if.sv
// Request/response bundle between the control FSM and the MULT/DIV sequencer.
// MULT_DIV_UNSIGNED_EN adds the is_unsigned request qualifier.
interface mult_div_seq_if
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
);

    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
`ifdef MULT_DIV_UNSIGNED_EN
    logic             is_unsigned;
`endif
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start_mult, start_div, op_a, op_b,
`ifdef MULT_DIV_UNSIGNED_EN
        output is_unsigned,
`endif
        input  hi_out, lo_out, busy, done, div_zero
    );

    modport slave (
        input  start_mult, start_div, op_a, op_b,
`ifdef MULT_DIV_UNSIGNED_EN
        input  is_unsigned,
`endif
        output hi_out, lo_out, busy, done, div_zero
    );

endinterface

// File: rtl/mult_div_seq_md_step.sv
// One iteration of the shared datapath: a radix-2 Booth step on {acc,q,q-1}
// or a restoring-division step on {rem,quo}, selected by mode_div.
module md_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             mode_div,
    input  logic [WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             qm1_in,
    input  logic [WIDTH:0]   opnd_in,
    output logic [WIDTH:0]   acc_out,
    output logic [WIDTH-1:0] q_out,
    output logic             qm1_out
);

    logic [WIDTH+1:0] booth_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        // One extra guard bit: a zero-extended multiplicand near 2^WIDTH can
        // push acc +/- opnd outside the WIDTH+1 signed range before the shift.
        case ({q_in[0], qm1_in})
            2'b01:   booth_sum = {acc_in[WIDTH], acc_in} + {opnd_in[WIDTH], opnd_in};
            2'b10:   booth_sum = {acc_in[WIDTH], acc_in} - {opnd_in[WIDTH], opnd_in};
            default: booth_sum = {acc_in[WIDTH], acc_in};
        endcase

        shifted = {acc_in[WIDTH-1:0], q_in[WIDTH-1]};
        trial   = {1'b0, shifted} - {1'b0, opnd_in};

        if (mode_div) begin
            acc_out = trial[WIDTH+1] ? shifted : trial[WIDTH:0];
            q_out   = {q_in[WIDTH-2:0], ~trial[WIDTH+1]};
            qm1_out = 1'b0;
        end else begin
            acc_out = booth_sum[WIDTH+1:1];
            q_out   = {booth_sum[0], q_in[WIDTH-1:1]};
            qm1_out = q_in[0];
        end
    end

endmodule

// File: rtl/mult_div_seq.sv
// Iterative signed MULT/DIV sequencer feeding HI/LO: FSM, counter, sign
// latches and result fixup. MULT_DIV_UNSIGNED_EN enables MULTU/DIVU requests.
module mult_div_seq
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic           clock,
    input  logic           reset,
    mult_div_seq_if.slave  bus
);

    localparam int CNT_W = md_cnt_width(WIDTH);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH:0]   opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic             uns_in;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   step_acc;
    logic [WIDTH-1:0] step_q;
    logic             step_qm1;

`ifdef MULT_DIV_UNSIGNED_EN
    assign uns_in = bus.is_unsigned;
`else
    assign uns_in = 1'b0;
`endif

    // Unsigned magnitudes; the most-negative value maps to 2^(WIDTH-1) correctly.
    assign a_mag = (bus.op_a[WIDTH-1] && !uns_in) ? -bus.op_a : bus.op_a;
    assign b_mag = (bus.op_b[WIDTH-1] && !uns_in) ? -bus.op_b : bus.op_b;

    md_step #(.WIDTH(WIDTH)) u_step (
        .mode_div (is_div_q),
        .acc_in   (acc_q),
        .q_in     (q_q),
        .qm1_in   (qm1_q),
        .opnd_in  (opnd_q),
        .acc_out  (step_acc),
        .q_out    (step_q),
        .qm1_out  (step_qm1)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        q_d        = q_q;
        qm1_d      = qm1_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
        b_msb_d    = b_msb_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_mult) begin
                    state_d   = MUL_IT;
                    cnt_d     = CNT_W'(WIDTH);
                    acc_d     = '0;
                    q_d       = bus.op_b;
                    qm1_d     = 1'b0;
                    opnd_d    = uns_in ? {1'b0, bus.op_a} : {bus.op_a[WIDTH-1], bus.op_a};
                    is_div_d  = 1'b0;
                    quo_neg_d = 1'b0;
                    rem_neg_d = 1'b0;
                    // Booth treats op_b as signed; an unsigned op_b with MSB set
                    // needs one more multiplicand added into the upper half.
                    b_msb_d   = uns_in & bus.op_b[WIDTH-1];
                    busy_d    = 1'b1;
                end else if (bus.start_div) begin
                    if (bus.op_b == '0) begin
                        div_zero_d = 1'b1;
                    end else begin
                        state_d   = DIV_IT;
                        cnt_d     = CNT_W'(WIDTH);
                        acc_d     = '0;
                        q_d       = a_mag;
                        qm1_d     = 1'b0;
                        opnd_d    = {1'b0, b_mag};
                        is_div_d  = 1'b1;
                        quo_neg_d = !uns_in && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        rem_neg_d = !uns_in && bus.op_a[WIDTH-1];
                        b_msb_d   = 1'b0;
                        busy_d    = 1'b1;
                    end
                end
            end

            MUL_IT, DIV_IT: begin
                acc_d = step_acc;
                q_d   = step_q;
                qm1_d = step_qm1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIXUP;
                end
            end

            FIXUP: begin
                if (is_div_q) begin
                    lo_d = quo_neg_q ? -q_q : q_q;
                    hi_d = rem_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end else begin
                    lo_d = q_q;
                    hi_d = acc_q[WIDTH-1:0] + (b_msb_q ? opnd_q[WIDTH-1:0] : '0);
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            q_q        <= '0;
            qm1_q      <= 1'b0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            b_msb_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            qm1_q      <= qm1_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            quo_neg_q  <= quo_neg_d;
            rem_neg_q  <= rem_neg_d;
            b_msb_q    <= b_msb_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq: the driver queues hand-computed results,
// a negedge monitor pops and checks them on every done/div_zero pulse.
module tb_mult_div_seq;

    logic clk;
    logic reset;
    int   cyc;
    int   n_tests;
    int   n_fail;

    typedef struct {
        string       name;
        bit          dz;
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t sb[$];

    mult_div_seq_if #(.WIDTH(32)) bus ();

    mult_div_seq #(.WIDTH(32)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done/div_zero pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (bus.done || bus.div_zero) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_output: done=%0b div_zero=%0b at cycle %0d, expected none",
                             bus.done, bus.div_zero, cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, ".kind"}, {31'd0, bus.div_zero}, {31'd0, e.dz});
                    check({e.name, ".cycle"}, cyc, e.due);
                    check({e.name, ".hi"}, bus.hi_out, e.hi);
                    check({e.name, ".lo"}, bus.lo_out, e.lo);
                    check({e.name, ".busy"}, {31'd0, bus.busy}, 32'd0);
                    $display("[TB] %s: hi=0x%08h lo=0x%08h cycle=%0d", e.name, bus.hi_out, bus.lo_out, cyc);
                end
            end else if (sb.size() != 0 && cyc > sb[0].due) begin
                e = sb.pop_front();
                n_tests++;
                n_fail++;
                $display("[TB] FAIL %s.missing: no output by cycle %0d, expected at %0d", e.name, cyc, e.due);
            end
        end
    end

    // Drive one request during a whole cycle; returns the edge index that samples it.
    task automatic issue(input string name, input bit m, input bit d,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit push, input bit dz,
                         input logic [31:0] eh, input logic [31:0] el,
                         output int edge_idx);
        exp_t e;
        @(negedge clk);
        bus.start_mult = m;
        bus.start_div  = d;
        bus.op_a       = a;
        bus.op_b       = b;
        edge_idx       = cyc + 1;
        if (push) begin
            e.name = name;
            e.dz   = dz;
            e.hi   = eh;
            e.lo   = el;
            e.due  = dz ? edge_idx : edge_idx + 33;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL %s.timeout: %0d results outstanding, expected 0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Full operation with a cycle-1 busy check; latency is checked by the monitor.
    task automatic run_op(input string name, input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        int e_idx;
        issue(name, m, d, a, b, 1'b1, 1'b0, eh, el, e_idx);
        @(negedge clk);
        check({name, ".busy_c1"}, {31'd0, bus.busy}, 32'd1);
        wait_idle(name);
    endtask

    // Operation with a stray start_div pulsed during cycle poke_cycle.
    task automatic run_poked(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] eh, input logic [31:0] el,
                             input int poke_cycle, input logic [31:0] poke_b);
        int e_idx;
        issue(name, 1'b1, 1'b0, a, b, 1'b1, 1'b0, eh, el, e_idx);
        repeat (poke_cycle) @(negedge clk);
        bus.start_div = 1'b1;
        bus.op_a      = 32'd100;
        bus.op_b      = poke_b;
        @(negedge clk);
        bus.start_div = 1'b0;
        wait_idle(name);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int e_idx;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.op_a       = 32'd0;
        bus.op_b       = 32'd0;
`ifdef MULT_DIV_UNSIGNED_EN
        bus.is_unsigned = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset.hi", bus.hi_out, 32'd0);
        check("reset.lo", bus.lo_out, 32'd0);
        check("reset.busy", {31'd0, bus.busy}, 32'd0);
        check("reset.done", {31'd0, bus.done}, 32'd0);
        check("reset.div_zero", {31'd0, bus.div_zero}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("mul_7x-3",    1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("div_-7/2",    1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);

        // Divide by zero: pulse in cycle 1, previous results retained.
        issue("div_5/0", 1'b0, 1'b1, 32'd5, 32'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, e_idx);
        @(negedge clk);
        check("div_5/0.busy_c1", {31'd0, bus.busy}, 32'd0);
        check("div_5/0.done_c1", {31'd0, bus.done}, 32'd0);
        wait_idle("div_5/0");
        repeat (40) @(negedge clk);

        run_op("div_ovf",     1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_poked("mul_poke10", 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 10, 32'd7);
        run_op("both_starts", 1'b1, 1'b1, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000002);
        run_op("mul_0x55",    1'b1, 1'b0, 32'd0,        32'h00000055, 32'h00000000, 32'h00000000);
        run_op("div_100/7",   1'b0, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14);
        run_op("div_-100/-7", 1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14);
        run_op("div_7/-100",  1'b0, 1'b1, 32'd7,        32'hFFFFFF9C, 32'd7,        32'd0);
        run_op("mul_min_min", 1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op("mul_-1x-1",   1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
        run_poked("mul_poke_done", 32'd3, 32'd5, 32'd0, 32'd15, 34, 32'd0);

        // Reset mid-divide: asserted during cycle 15, everything clear in cycle 16.
        issue("div_reset", 1'b0, 1'b1, 32'd1000, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0, e_idx);
        repeat (15) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset.busy", {31'd0, bus.busy}, 32'd0);
        check("mid_reset.hi", bus.hi_out, 32'd0);
        check("mid_reset.lo", bus.lo_out, 32'd0);
        check("mid_reset.done", {31'd0, bus.done}, 32'd0);
        $display("[TB] mid_reset: busy=%0b hi=0x%08h lo=0x%08h", bus.busy, bus.hi_out, bus.lo_out);
        reset = 1'b1;
        repeat (45) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
